// File: rtl/idu_pipe.sv
// Instruction decode stage: RV32I decode, register file read/write and a single
// registered output slot. Optional macro IDU_WR_BYPASS_EN forwards same-cycle writes to reads.
module idu_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] PC_now,
  input  logic              flush,
  input  logic              W_en,
  input  logic [4:0]        W_addr,
  input  logic [DATA_W-1:0] Wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        func3,
  output logic              func7,
  output logic [4:0]        Rd,
  output logic [DATA_W-1:0] imme,
  output logic [DATA_W-1:0] PC_add_imme,
  output logic [DATA_W-1:0] regs_rs1_data,
  output logic [DATA_W-1:0] regs_rs2_data,
  output logic [DATA_W-1:0] PC_out,
  output logic [8:0]        instr_class,
  output logic              illegal
);

  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic [DATA_W-1:0] r_regs [REG_NUM];

  logic              r_out_valid;
  logic [2:0]        r_func3;
  logic              r_func7;
  logic [4:0]        r_rd;
  logic [DATA_W-1:0] r_imme;
  logic [DATA_W-1:0] r_pc_add_imme;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
  logic [DATA_W-1:0] r_pc_out;
  logic [8:0]        r_class;
  logic              r_illegal;

  logic              w_accept;
  logic              w_load;
  logic              w_we;
  logic [4:0]        w_rs1;
  logic [4:0]        w_rs2;
  logic              w_rs1_oob;
  logic              w_rs2_oob;
  logic [8:0]        w_class;
  logic              w_bad_op;
  logic [31:0]       w_imm32;
  logic [DATA_W-1:0] w_imme;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;

  assign in_ready = !r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept & !flush;
  assign w_we     = W_en & (W_addr != 5'd0) & (32'(W_addr) < 32'(REG_NUM));

  assign w_rs1     = instr[19:15];
  assign w_rs2     = instr[24:20];
  assign w_rs1_oob = 32'(w_rs1) >= 32'(REG_NUM);
  assign w_rs2_oob = 32'(w_rs2) >= 32'(REG_NUM);

  // Class bits: {B,AUIPC,LUI,JALR,JAL,R,S,L,I}
  always_comb begin
    w_class  = 9'd0;
    w_bad_op = 1'b0;
    w_imm32  = 32'd0;
    case (instr[6:0])
      7'b0010011: begin w_class = 9'h001; w_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      7'b0000011: begin w_class = 9'h002; w_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      7'b0100011: begin w_class = 9'h004; w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]}; end
      7'b0110011: begin w_class = 9'h008; end
      7'b1101111: begin
        w_class = 9'h010;
        w_imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      7'b1100111: begin w_class = 9'h020; w_imm32 = {{20{instr[31]}}, instr[31:20]}; end
      7'b0110111: begin w_class = 9'h040; w_imm32 = {instr[31:12], 12'd0}; end
      7'b0010111: begin w_class = 9'h080; w_imm32 = {instr[31:12], 12'd0}; end
      7'b1100011: begin
        w_class = 9'h100;
        w_imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default:    begin w_bad_op = 1'b1; end
    endcase
  end

  assign w_imme = DATA_W'($signed(w_imm32));

  // Out-of-range and x0 indices read as zero; bypass only applies to writable registers.
  always_comb begin
    w_rs1_data = '0;
    w_rs2_data = '0;
    if (w_rs1 != 5'd0 && !w_rs1_oob) begin
      w_rs1_data = r_regs[w_rs1[AW-1:0]];
`ifdef IDU_WR_BYPASS_EN
      if (W_en && W_addr == w_rs1) w_rs1_data = Wr_data;
`endif
    end
    if (w_rs2 != 5'd0 && !w_rs2_oob) begin
      w_rs2_data = r_regs[w_rs2[AW-1:0]];
`ifdef IDU_WR_BYPASS_EN
      if (W_en && W_addr == w_rs2) w_rs2_data = Wr_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[W_addr[AW-1:0]] <= Wr_data;
    end
  end

  // Output slot: flush beats accept, accept beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func3       <= '0;
      r_func7       <= 1'b0;
      r_rd          <= '0;
      r_imme        <= '0;
      r_pc_add_imme <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_pc_out      <= '0;
      r_class       <= '0;
      r_illegal     <= 1'b0;
    end else if (w_load) begin
      r_func3       <= instr[14:12];
      r_func7       <= instr[30];
      r_rd          <= instr[11:7];
      r_imme        <= w_imme;
      r_pc_add_imme <= PC_now + w_imme;
      r_rs1_data    <= w_rs1_data;
      r_rs2_data    <= w_rs2_data;
      r_pc_out      <= PC_now;
      r_class       <= w_class;
      r_illegal     <= w_bad_op | w_rs1_oob | w_rs2_oob;
    end
  end

  assign out_valid     = r_out_valid;
  assign func3         = r_func3;
  assign func7         = r_func7;
  assign Rd            = r_rd;
  assign imme          = r_imme;
  assign PC_add_imme   = r_pc_add_imme;
  assign regs_rs1_data = r_rs1_data;
  assign regs_rs2_data = r_rs2_data;
  assign PC_out        = r_pc_out;
  assign instr_class   = r_class;
  assign illegal       = r_illegal;

endmodule

// File: doc/idu_pipe.md
IDU_PIPE -- requirements
Module: idu_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, datapath and register width (32 or 64).
REQ-002 SHALL provide parameter REG_NUM, default 32, general-register count (power of 2, 2..32).
REQ-003 SHALL provide ports: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide: in_valid  input  1; in_ready  output  1; instr  input  32; PC_now  input  DATA_W.
REQ-006 SHALL provide: flush  input  1  discard held decoded entry.
REQ-007 SHALL provide: W_en  input  1; W_addr  input  5; Wr_data  input  DATA_W  register write port.
REQ-008 SHALL provide: out_valid  output  1; out_ready  input  1  downstream handshake.
REQ-009 SHALL provide registered outputs: func3 (3), func7 (1), Rd (5), imme (DATA_W), PC_add_imme (DATA_W), regs_rs1_data (DATA_W), regs_rs2_data (DATA_W), PC_out (DATA_W).
REQ-010 SHALL provide registered output instr_class (9), one-hot {B,AUIPC,LUI,JALR,JAL,R,S,L,I} from MSB to LSB, plus illegal (1).

Function
REQ-011 Decode SHALL follow RV32I base opcodes; imme sign-extended to DATA_W per I/S/B/U/J format; U-type imme = instr[31:12]<<12, sign-extended.
REQ-012 Unrecognised opcode SHALL set illegal=1, instr_class=0, and otherwise be passed like any entry.
REQ-013 PC_add_imme SHALL be PC_now+imme modulo 2^DATA_W (wrap, no carry out).
REQ-014 Single output stage: in_ready = !out_valid | out_ready (combinational).
REQ-015 Accept occurs when in_valid & in_ready; all outputs load on that edge, out_valid=1; latency exactly 1 cycle.
REQ-016 out_valid & out_ready with no accept SHALL clear out_valid next edge; with accept, back-to-back throughput 1/cycle.
REQ-017 While out_valid & !out_ready, all outputs SHALL hold stable, including regs_rs1_data/regs_rs2_data captured at accept.
REQ-018 flush SHALL clear out_valid next edge and SHALL override a simultaneous accept (new instr dropped); in_ready unaffected by flush.
REQ-019 Register file: REG_NUM x DATA_W; write on edge when W_en & W_addr!=0 & W_addr<REG_NUM; register 0 reads 0 always.
REQ-020 Rs1/Rs2 index >= REG_NUM SHALL read 0 and set illegal=1.
REQ-021 Register writes SHALL proceed every cycle regardless of stall or flush.

Reset
REQ-022 While rst_n=0: out_valid=0, all registered outputs 0, all general registers 0; in_ready=1 after reset.
REQ-023 Reset asserted mid-stall SHALL discard the held entry; no accept on the edge of rst_n release.

Configuration
REQ-024 Macro IDU_WR_BYPASS_EN defined: a read of register r in the accept cycle while W_en & W_addr==r (r!=0) SHALL return Wr_data.
REQ-025 Macro IDU_WR_BYPASS_EN undefined: that read SHALL return the old register value; the write lands at the edge.

Verification
REQ-026 Reset then write x5=0x1234, accept ADDI x1,x5,-1 (0xFFF28093), PC_now=0x100 -> next cycle out_valid=1, instr_class[0]=1, Rd=1, imme=0xFFFFFFFF, regs_rs1_data=0x1234, PC_add_imme=0xFF.
REQ-027 Hold out_ready=0 for 3 cycles after accept, write x5=0x9 meanwhile -> outputs unchanged, in_ready=0, regs_rs1_data stays 0x1234.
REQ-028 Same-cycle W_en x5=0xAAAA and accept reading x5 -> regs_rs1_data=0xAAAA with IDU_WR_BYPASS_EN, 0x1234 without.
REQ-029 flush and accept in same cycle -> out_valid=0 next cycle; write to x0 then read x0 -> 0.
REQ-030 JAL with imme -4 at PC_now=0x0 -> PC_add_imme=0xFFFFFFFC (wrap); opcode 0x7F -> illegal=1, instr_class=0.
